// File: rtl/loop_sequencer_if.sv
// rtl/loop_sequencer_if.sv - decode-to-loop-sequencer instruction handshake
interface loop_sequencer_if #(
  parameter int BITS    = 15,
  parameter int PC_BITS = 16
);
  logic               instr_valid;
  logic               instr_ready;
  logic [1:0]         instr_kind;
  logic [PC_BITS-1:0] instr_pc;
  logic [BITS-1:0]    instr_count;
  logic               instr_independent;

  modport master (
    output instr_valid, instr_kind, instr_pc, instr_count, instr_independent,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_kind, instr_pc, instr_count, instr_independent,
    output instr_ready
  );
endinterface

// File: rtl/loop_sequencer.sv
// rtl/loop_sequencer.sv - LOOP_START/LOOP_END to loop-stack strobes, PC stack, fetch redirect
// Optional feature macro: LOOP_SEQ_INDEPENDENT_EN (inner independent loops, multi-copy issue)
module loop_sequencer #(
  parameter int BITS                  = 15,
  parameter int LOOP_LOG_CNT          = 2,
  parameter int SUPERSCALAR_LOG_WIDTH = 2,
  parameter int PC_BITS               = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  loop_sequencer_if.slave                  instr,
  output logic                             ls_create,
  output logic [BITS-1:0]                  ls_count,
  output logic                             ls_independent,
  output logic                             ls_next_iter,
  output logic                             ls_finish,
  input  logic                             ls_done,
  input  logic [SUPERSCALAR_LOG_WIDTH-1:0] ls_copy_count,
  output logic                             redirect_valid,
  output logic [PC_BITS-1:0]               redirect_pc,
  output logic [SUPERSCALAR_LOG_WIDTH:0]   issue_copies,
  output logic [LOOP_LOG_CNT:0]            depth,
  output logic                             err_overflow,
  output logic                             err_underflow
);
  localparam int MAX_DEPTH = 1 << LOOP_LOG_CNT;
  localparam logic [1:0] KIND_START = 2'b01;
  localparam logic [1:0] KIND_END   = 2'b10;
  localparam logic [LOOP_LOG_CNT:0] DEPTH_FULL = (LOOP_LOG_CNT+1)'(MAX_DEPTH);
  localparam logic [LOOP_LOG_CNT:0] DEPTH_ONE  = (LOOP_LOG_CNT+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_CHECK, S_NEXT, S_FINISH} state_t;
  state_t state, next_state;

  logic [PC_BITS-1:0]      pc_stack [MAX_DEPTH];
  logic                    accept, is_start, is_end, at_full, at_empty, do_push;
  logic [LOOP_LOG_CNT-1:0] push_idx, top_idx;

  assign instr.instr_ready = (state == S_IDLE);
  assign accept   = instr.instr_valid && (state == S_IDLE);
  assign is_start = accept && (instr.instr_kind == KIND_START);
  assign is_end   = accept && (instr.instr_kind == KIND_END);
  assign at_full  = (depth == DEPTH_FULL);
  assign at_empty = (depth == '0);
  assign do_push  = is_start && !at_full;
  // push_idx wraps to 0 at full depth, but no push happens then
  assign push_idx = depth[LOOP_LOG_CNT-1:0];
  assign top_idx  = push_idx - LOOP_LOG_CNT'(1);

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (do_push) next_state = S_START;
        else if (is_end && !at_empty) next_state = S_CHECK;
      end
      S_START:  next_state = S_IDLE;
      S_CHECK:  next_state = ls_done ? S_FINISH : S_NEXT;
      default:  next_state = S_IDLE;
    endcase
  end

  // Strobes are registered images of the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      depth          <= '0;
      ls_create      <= 1'b0;
      ls_next_iter   <= 1'b0;
      ls_finish      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      ls_count       <= '0;
      ls_independent <= 1'b0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      state          <= next_state;
      ls_create      <= (next_state == S_START);
      ls_next_iter   <= (next_state == S_NEXT);
      ls_finish      <= (next_state == S_FINISH);
      redirect_valid <= (next_state == S_NEXT);
      if (next_state == S_NEXT) redirect_pc <= pc_stack[top_idx];
      if (do_push) begin
        ls_count <= (instr.instr_count == '0) ? BITS'(1) : instr.instr_count;
`ifdef LOOP_SEQ_INDEPENDENT_EN
        ls_independent <= instr.instr_independent;
`else
        ls_independent <= 1'b0;
`endif
      end
      if (is_start && at_full) err_overflow <= 1'b1;
      if (is_end && at_empty) err_underflow <= 1'b1;
      if (state == S_START) depth <= depth + DEPTH_ONE;
      else if (state == S_FINISH) depth <= depth - DEPTH_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) pc_stack[push_idx] <= instr.instr_pc + PC_BITS'(1);
  end

`ifdef LOOP_SEQ_INDEPENDENT_EN
  assign issue_copies = {1'b0, ls_copy_count} + (SUPERSCALAR_LOG_WIDTH+1)'(1);
`else
  logic unused_inputs;
  assign unused_inputs = ^{ls_copy_count, instr.instr_independent};
  assign issue_copies  = (SUPERSCALAR_LOG_WIDTH+1)'(1);
`endif
endmodule

// File: tb/tb_loop_sequencer.sv
// tb/tb_loop_sequencer.sv - vector table plus strobe scoreboard for loop_sequencer
module tb_loop_sequencer;
  localparam int BITS = 15;
  localparam int LLC  = 2;
  localparam int SLW  = 2;
  localparam int PCB  = 16;
  localparam logic [2:0] EV_CREATE = 3'b001;
  localparam logic [2:0] EV_NEXT   = 3'b010;
  localparam logic [2:0] EV_FINISH = 3'b100;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] pc;
    logic [14:0] cnt;
    logic        ind;
    logic        done;
    logic [2:0]  exp_depth;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] val;
    logic        ind;
    int          due;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ls_done = 1'b0;
  logic [SLW-1:0] ls_copy_count = '0;
  logic ls_create, ls_independent, ls_next_iter, ls_finish, redirect_valid;
  logic err_overflow, err_underflow;
  logic [BITS-1:0] ls_count;
  logic [PCB-1:0]  redirect_pc;
  logic [SLW:0]    issue_copies;
  logic [LLC:0]    depth;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  vec_t vecs[$];
  ev_t  sb[$];
  logic [15:0] m_stack[$];
  ev_t  mon_e;
  logic [2:0] mon_act;

  loop_sequencer_if #(.BITS(BITS), .PC_BITS(PCB)) ifc ();

  loop_sequencer #(
    .BITS(BITS), .LOOP_LOG_CNT(LLC), .SUPERSCALAR_LOG_WIDTH(SLW), .PC_BITS(PCB)
  ) dut (
    .clk(clk), .reset(reset), .instr(ifc),
    .ls_create(ls_create), .ls_count(ls_count), .ls_independent(ls_independent),
    .ls_next_iter(ls_next_iter), .ls_finish(ls_finish), .ls_done(ls_done),
    .ls_copy_count(ls_copy_count), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .issue_copies(issue_copies), .depth(depth),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_ind(input logic ind);
`ifdef LOOP_SEQ_INDEPENDENT_EN
    return ind;
`else
    return 1'b0 & ind;
`endif
  endfunction

  task automatic add(input logic [1:0] k, input logic [15:0] pc, input logic [14:0] cnt,
                     input logic ind, input logic done, input logic [2:0] d,
                     input logic ovf, input logic unf);
    vec_t v;
    v.kind = k; v.pc = pc; v.cnt = cnt; v.ind = ind; v.done = done;
    v.exp_depth = d; v.exp_ovf = ovf; v.exp_unf = unf;
    vecs.push_back(v);
  endtask

  // Model: pushes expected strobes with their due cycle, checks ready latency
  task automatic send(input logic [1:0] k, input logic [15:0] pc, input logic [14:0] cnt,
                      input logic ind, input logic done);
    int n, h, due_ready;
    ev_t e;
    logic [15:0] ret_pc;
    ifc.instr_valid = 1'b1; ifc.instr_kind = k; ifc.instr_pc = pc;
    ifc.instr_count = cnt; ifc.instr_independent = ind;
    n = 0;
    while (!ifc.instr_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("handshake_timeout", 0, 1);
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    ls_done = done;
    h = cyc;
    due_ready = h;
    if (k == 2'b01) begin
      if (m_stack.size() < 4) begin
        e.kind = EV_CREATE; e.val = 16'((cnt == 15'd0) ? 15'd1 : cnt);
        e.ind = exp_ind(ind); e.due = h;
        sb.push_back(e);
        ret_pc = pc + 16'd1;
        m_stack.push_back(ret_pc);
        due_ready = h + 1;
      end
    end else if (k == 2'b10) begin
      if (m_stack.size() > 0) begin
        e.ind = 1'b0; e.due = h + 1;
        if (done) begin
          e.kind = EV_FINISH; e.val = 16'h0;
          void'(m_stack.pop_back());
        end else begin
          e.kind = EV_NEXT; e.val = m_stack[$];
        end
        sb.push_back(e);
        due_ready = h + 2;
      end
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!ifc.instr_ready && n < 20);
    chk("ready_latency", cyc, due_ready);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_act = {ls_finish, ls_next_iter, ls_create};
      chk("strobe_onehot", 32'($countones(mon_act) <= 1), 1);
      chk("redirect_with_next", redirect_valid, ls_next_iter);
      if (sb.size() != 0 && sb[0].due < cyc) begin
        chk("missing_strobe", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (mon_act != 3'b000) begin
        if (sb.size() == 0) chk("unexpected_strobe", mon_act, 0);
        else begin
          mon_e = sb.pop_front();
          chk("strobe_kind", mon_act, mon_e.kind);
          chk("strobe_cycle", cyc, mon_e.due);
          if (mon_e.kind == EV_CREATE) begin
            chk("ls_count", ls_count, mon_e.val);
            chk("ls_independent", ls_independent, mon_e.ind);
          end else if (mon_e.kind == EV_NEXT) begin
            chk("redirect_pc", redirect_pc, mon_e.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    ifc.instr_valid = 1'b0; ifc.instr_kind = 2'b00; ifc.instr_pc = '0;
    ifc.instr_count = '0; ifc.instr_independent = 1'b0;

    //   kind   pc        cnt       ind done depth ovf unf
    add(2'b01, 16'h0010, 15'd3,    0, 0, 3'd1, 0, 0);
    add(2'b10, 16'h0000, 15'd0,    0, 0, 3'd1, 0, 0);
    add(2'b10, 16'h0000, 15'd0,    0, 0, 3'd1, 0, 0);
    add(2'b10, 16'h0000, 15'd0,    0, 1, 3'd0, 0, 0);
    add(2'b00, 16'h0030, 15'd9,    1, 0, 3'd0, 0, 0);
    add(2'b11, 16'h0031, 15'd9,    1, 0, 3'd0, 0, 0);
    add(2'b01, 16'h0020, 15'd2,    0, 0, 3'd1, 0, 0);
    add(2'b01, 16'h0022, 15'd2,    1, 0, 3'd2, 0, 0);
    add(2'b10, 16'h0000, 15'd0,    0, 0, 3'd2, 0, 0);
    add(2'b10, 16'h0000, 15'd0,    0, 1, 3'd1, 0, 0);
    add(2'b10, 16'h0000, 15'd0,    0, 0, 3'd1, 0, 0);
    add(2'b10, 16'h0000, 15'd0,    0, 1, 3'd0, 0, 0);
    add(2'b01, 16'hFFFF, 15'd0,    1, 0, 3'd1, 0, 0);
    add(2'b10, 16'h0000, 15'd0,    0, 0, 3'd1, 0, 0);
    add(2'b10, 16'h0000, 15'd0,    0, 1, 3'd0, 0, 0);
    add(2'b10, 16'h0000, 15'd0,    0, 0, 3'd0, 0, 1);
    add(2'b01, 16'h0100, 15'h7FFF, 1, 0, 3'd1, 0, 1);
    add(2'b01, 16'h0200, 15'd6,    0, 0, 3'd2, 0, 1);
    add(2'b01, 16'h0300, 15'd7,    1, 0, 3'd3, 0, 1);
    add(2'b01, 16'h0400, 15'd8,    0, 0, 3'd4, 0, 1);
    add(2'b01, 16'h0500, 15'd9,    0, 0, 3'd4, 1, 1);
    add(2'b10, 16'h0000, 15'd0,    0, 0, 3'd4, 1, 1);
    add(2'b10, 16'h0000, 15'd0,    0, 1, 3'd3, 1, 1);
    add(2'b10, 16'h0000, 15'd0,    0, 1, 3'd2, 1, 1);
    add(2'b10, 16'h0000, 15'd0,    0, 1, 3'd1, 1, 1);
    add(2'b10, 16'h0000, 15'd0,    0, 1, 3'd0, 1, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_create", ls_create, 0);
    chk("rst_next", ls_next_iter, 0);
    chk("rst_finish", ls_finish, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_ls_count", ls_count, 0);
    chk("rst_ls_independent", ls_independent, 0);
    chk("rst_depth", depth, 0);
    chk("rst_err_ovf", err_overflow, 0);
    chk("rst_err_unf", err_underflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ifc.instr_ready, 1);

    foreach (vecs[i]) begin
      send(vecs[i].kind, vecs[i].pc, vecs[i].cnt, vecs[i].ind, vecs[i].done);
      chk($sformatf("v%0d_depth", i), depth, vecs[i].exp_depth);
      chk($sformatf("v%0d_err_ovf", i), err_overflow, vecs[i].exp_ovf);
      chk($sformatf("v%0d_err_unf", i), err_underflow, vecs[i].exp_unf);
      chk($sformatf("v%0d_drained", i), sb.size(), 0);
    end

    for (int c = 0; c < 4; c++) begin
      ls_copy_count = SLW'(c);
      #1;
`ifdef LOOP_SEQ_INDEPENDENT_EN
      chk($sformatf("issue_copies_%0d", c), issue_copies, c + 1);
`else
      chk($sformatf("issue_copies_%0d", c), issue_copies, 1);
`endif
    end
    @(negedge clk);

    // Reset landing on the CHECK cycle of a LOOP_END must suppress its strobe
    send(2'b01, 16'h0050, 15'd4, 0, 0);
    chk("abort_pre_depth", depth, 1);
    ifc.instr_kind = 2'b10; ifc.instr_valid = 1'b1;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0; ls_done = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_stack.delete();
    repeat (5) @(negedge clk);
    chk("abort_depth", depth, 0);
    chk("abort_err_ovf", err_overflow, 0);
    chk("abort_err_unf", err_underflow, 0);
    chk("abort_ready", ifc.instr_ready, 1);
    chk("abort_redirect", redirect_valid, 0);

    send(2'b01, 16'h0070, 15'd1, 0, 0);
    send(2'b10, 16'h0000, 15'd0, 0, 1);
    chk("recover_depth", depth, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
